// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared types for the battleship turn controller
// Purpose: game-sequencing state encoding and per-player display codes.
// Ports: none (package).
package battleship_pkg;

    typedef enum logic [2:0] {
        S_SETUP    = 3'd0,
        S_AIM      = 3'd1,
        S_FIRE     = 3'd2,
        S_ERROR    = 3'd3,
        S_RESOLVE  = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        DISP_OFF   = 3'd0,
        DISP_AIM   = 3'd1,
        DISP_VIEW  = 3'd2,
        DISP_ERROR = 3'd5,
        DISP_WIN   = 3'd6,
        DISP_LOSE  = 3'd7
    } disp_mode_t;

endpackage

// File: rtl/battleship_turn_ctrl_if.sv
// rtl/battleship_turn_ctrl_if.sv - player-side signal bundle of the turn controller
// Purpose: groups game inputs (start/fire/alive/ok) and controller outputs.
// Modports: master = controller (drives enables/displays/status),
//           slave  = board/player side (drives start/fire/alive/ok).
interface battleship_turn_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int TURN_W      = 8
);
    localparam int PW = $clog2(NUM_PLAYERS);

    logic                     start;
    logic [NUM_PLAYERS-1:0]   fire;
    logic [NUM_PLAYERS-1:0]   alive;
    logic [NUM_PLAYERS-1:0]   ok;
    logic [NUM_PLAYERS-1:0]   ld_ships;
    logic [NUM_PLAYERS-1:0]   ld_attack;
    logic [3*NUM_PLAYERS-1:0] disp_mode;
    logic                     setup;
    logic [PW-1:0]            active_player;
    logic [PW-1:0]            target_player;
    logic [PW-1:0]            winner;
    logic                     game_over;
    logic [TURN_W-1:0]        turn_count;

    modport master (
        input  start, fire, alive, ok,
        output ld_ships, ld_attack, disp_mode, setup, active_player,
               target_player, winner, game_over, turn_count
    );

    modport slave (
        output start, fire, alive, ok,
        input  ld_ships, ld_attack, disp_mode, setup, active_player,
               target_player, winner, game_over, turn_count
    );

endinterface

// File: rtl/bs_next_alive.sv
// rtl/bs_next_alive.sv - round-robin finder of the next alive player
// Purpose: returns the first set bit of alive strictly after start_idx, wrapping.
// Ports: alive (N) in, start_idx (PW) in, idx (PW) out, found out.
module bs_next_alive #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  alive,
    input  logic [PW-1:0] start_idx,
    output logic [PW-1:0] idx,
    output logic          found
);

    logic [PW:0] pos;

    // Walk the distances from farthest to nearest so the nearest hit is the
    // one left standing; start_idx itself is never a candidate.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = N - 1; k >= 1; k--) begin
            pos = {1'b0, start_idx} + (PW + 1)'(k);
            if (pos >= (PW + 1)'(N)) begin
                pos = pos - (PW + 1)'(N);
            end
            if (alive[pos[PW-1:0]]) begin
                idx   = pos[PW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/battleship_turn_ctrl.sv
// rtl/battleship_turn_ctrl.sv - N-player battleship turn sequencer
// Purpose: round-robin turns skipping eliminated players, timed error display,
//          win/lose detection and a saturating turn counter.
// Ports: clk, clr (sync, active-high), bus (master modport): start/fire/alive/ok
//        in; ld_ships/ld_attack/disp_mode/setup/active_player/target_player/
//        winner/game_over/turn_count out.
module battleship_turn_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int ERR_CYCLES  = 50_000_000,
    parameter int TURN_W      = 8
) (
    input  logic                      clk,
    input  logic                      clr,
    battleship_turn_ctrl_if.master    bus
);
    import battleship_pkg::*;

    localparam int PW = $clog2(NUM_PLAYERS);
    localparam int TW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

    state_t                 state, state_nxt;
    logic [PW-1:0]          active, target, win;
    logic [TURN_W-1:0]      turns;
    logic [TW-1:0]          tmr;
    logic [NUM_PLAYERS-1:0] fire_q, rise;
    logic [PW-1:0]          nxt_act, nxt_tgt;
    logic                   act_found, tgt_found;
    logic                   multi;

    assign rise  = bus.fire & ~fire_q;
    assign multi = $countones(bus.alive) > 1;

    bs_next_alive #(.N(NUM_PLAYERS), .PW(PW)) u_next_act (
        .alive(bus.alive), .start_idx(active), .idx(nxt_act), .found(act_found)
    );

    bs_next_alive #(.N(NUM_PLAYERS), .PW(PW)) u_next_tgt (
        .alive(bus.alive), .start_idx(nxt_act), .idx(nxt_tgt), .found(tgt_found)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= S_SETUP;
            active <= '0;
            target <= PW'(1);
            win    <= '0;
            turns  <= '0;
            tmr    <= '0;
            fire_q <= '0;
        end else begin
            state  <= state_nxt;
            fire_q <= bus.fire;
            case (state)
                S_FIRE: if (!bus.ok[active]) tmr <= TW'(ERR_CYCLES - 1);
                S_ERROR: if (tmr != '0) tmr <= tmr - TW'(1);
                S_RESOLVE: begin
                    if (multi) begin
                        if (turns != '1) turns <= turns + TURN_W'(1);
                        active <= nxt_act;
                        target <= tgt_found ? nxt_tgt : target;
                    end else begin
                        // No other alive player found means the active one is
                        // the survivor, or nobody survived; both name active.
                        win <= act_found ? nxt_act : active;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_SETUP:    if (bus.start && (&bus.alive)) state_nxt = S_AIM;
            S_AIM:      if (rise[active]) state_nxt = S_FIRE;
            S_FIRE:     state_nxt = bus.ok[active] ? S_RESOLVE : S_ERROR;
            S_ERROR:    if (tmr == '0) state_nxt = S_AIM;
            S_RESOLVE:  state_nxt = multi ? S_AIM : S_GAMEOVER;
            S_GAMEOVER: state_nxt = S_GAMEOVER;
            default:    state_nxt = S_SETUP;
        endcase
    end

    always_comb begin
        bus.ld_ships  = '0;
        bus.ld_attack = '0;
        bus.disp_mode = '0;
        bus.setup     = 1'b0;
        bus.game_over = 1'b0;
        case (state)
            S_SETUP: begin
                bus.ld_ships = '1;
                bus.setup    = 1'b1;
            end
            S_AIM, S_FIRE, S_ERROR: begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (PW'(i) != active)
                        bus.disp_mode[3*i +: 3] = DISP_VIEW;
                    else if (state == S_ERROR)
                        bus.disp_mode[3*i +: 3] = DISP_ERROR;
                    else
                        bus.disp_mode[3*i +: 3] = DISP_AIM;
                end
                if (state == S_FIRE) begin
                    bus.ld_attack[active] = 1'b1;
                    bus.ld_ships[target]  = 1'b1;
                end
            end
            S_GAMEOVER: begin
                bus.game_over = 1'b1;
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    bus.disp_mode[3*i +: 3] = (PW'(i) == win) ? DISP_WIN : DISP_LOSE;
                end
            end
            default: ;
        endcase
    end

    assign bus.active_player = active;
    assign bus.target_player = target;
    assign bus.winner        = win;
    assign bus.turn_count    = turns;

endmodule

// File: doc/battleship_turn_ctrl.md
Name: battleship_turn_ctrl

Overview:
Parametrised game-sequencing controller for the Basys battleship game. It is the generalised successor of the two-player turn FSM and supports NUM_PLAYERS players with round-robin turns that skip eliminated players. It adds a timed error display, win/lose detection and a turn counter. It drives the per-player ship-register and attack-register load enables and the per-player display-mode selects.

Parameters:
NUM_PLAYERS, 2, number of players; legal range 2..8.
ERR_CYCLES, 50_000_000, number of clk cycles the ERROR display is held after an invalid attack; must be at least 1.
TURN_W, 8, width of the turn counter.
PW (localparam), $clog2(NUM_PLAYERS), width of a player index.

Ports:
clk  in  1  system clock.
clr  in  1  reset; synchronous, active-high.
start  in  1  level; players have finished placing ships.
fire  in  NUM_PLAYERS  per-player attack button, debounced level.
alive  in  NUM_PLAYERS  player i still has at least one unsunk ship.
ok  in  NUM_PLAYERS  attack entry of player i changes exactly one position.
ld_ships  out  NUM_PLAYERS  load enable, player i ship/hit register.
ld_attack  out  NUM_PLAYERS  load enable, player i attack register.
disp_mode  out  3*NUM_PLAYERS  3-bit display code per player; player i occupies [3i+2:3i].
setup  out  1  high while in SETUP.
active_player  out  PW  index of the player whose turn it is.
target_player  out  PW  index of the player being attacked.
winner  out  PW  valid while game_over is high.
game_over  out  1  high in GAMEOVER.
turn_count  out  TURN_W  number of completed valid turns; saturates at all-ones.

Behaviour:
- Reset: clr is sampled on the clk edge. On the next cycle state=SETUP, active=0, target=1, winner=0, turn_count=0, error timer=0, fire_q=0. clr overrides every other input and applies in any state, including mid-ERROR and GAMEOVER.
- Outputs are Moore, decoded from registered state, active and target. Defaults: all enables 0, all disp_mode OFF.
- Display codes: OFF=0, AIM=1, VIEW=2, ERROR=5, WIN=6, LOSE=7.
- Fire edge detection: fire_q registers fire every cycle; rise = fire & ~fire_q. Only rise[active] is used; a fire button held across a state change never counts as a new press.
- SETUP:
  - ld_ships = all 1s, setup = 1, disp_mode = all OFF.
  - -> AIM when start is high and alive is all 1s.
  - start is ignored if any player has no ships.
- AIM:
  - disp_mode[active] = AIM; all others VIEW.
  - -> FIRE on rise[active].
- FIRE (exactly 1 cycle):
  - ld_attack[active] = 1, ld_ships[target] = 1; displays as in AIM.
  - ok[active] is sampled this cycle: ok -> RESOLVE; else -> ERROR with timer loaded to ERR_CYCLES-1.
- ERROR:
  - disp_mode[active] = ERROR; others VIEW.
  - Timer decrements each cycle; when the timer is 0 -> AIM with the same active player.
  - fire presses during ERROR are ignored but still update fire_q.
- RESOLVE (1 cycle; alive now reflects the register load):
  - If popcount(alive) <= 1: -> GAMEOVER.
    - winner = the alive player.
    - If none is alive, winner = active.
  - Otherwise:
    - turn_count += 1, saturating.
    - active = next alive index after active, wrapping modulo NUM_PLAYERS.
    - target = next alive index after the new active.
    - -> AIM.
- GAMEOVER:
  - disp_mode[winner] = WIN; all others LOSE; game_over = 1.
  - Holds until clr.
- Boundary conditions:
  - With NUM_PLAYERS=2, behaviour is identical to the original A/B ping-pong, plus the win handling.
  - target never equals active while two or more players are alive.
  - The active player's alive bit is not checked at AIM entry; only the target can lose ships on a turn.

Decomposition:
- battleship_pkg: state_t enum (SETUP, AIM, FIRE, ERROR, RESOLVE, GAMEOVER), disp_mode_t 3-bit enum and the code constants above.
- Sub-module bs_next_alive: combinational round-robin finder.
  - Inputs: alive vector and a start index.
  - Outputs: the first set index strictly after the start index (wrapping), plus a found flag.
  - Instantiated twice, once for the new active and once for the new target.

Test Plan:
1. N=2, ERR_CYCLES=4. Reset; start=1 with alive=2'b01 -> stays in SETUP, setup=1, ld_ships=2'b11. Then alive=2'b11 -> next cycle AIM, active=0, disp_mode={VIEW,AIM}.
2. N=2. Pulse fire[0] with ok[0]=1 -> one cycle of ld_attack=2'b01, ld_ships=2'b10. Then RESOLVE, then AIM with active=1, target=0, turn_count=1.
3. N=2, ERR_CYCLES=4. fire[0] with ok[0]=0 -> disp_mode[0]=ERROR for exactly 4 cycles, then AIM with active=0 and turn_count unchanged. fire[0] held high throughout -> no new FIRE until it is released and pressed again.
4. N=3, all alive. Player 0 fires at 1, valid, and alive becomes 3'b101 -> active=2, target=0. The next valid turn -> active=0, target=2, and player 1 is never selected again.
5. N=2. Valid attack by player 1 that drops alive to 2'b10 -> GAMEOVER, winner=1, disp_mode={WIN,LOSE}, game_over=1. Further fire pulses are ignored.
6. Assert clr in the middle of ERROR and in GAMEOVER -> one cycle later state=SETUP and all outputs at their reset values. Also apply 300 valid turns with TURN_W=8 -> turn_count saturates at 255.
